sd4_accumulator: RTL and testbench

Downstream stage of `partial_product_generator` in the SD4 MAC datapath.
- Accepts a stream of signed-digit partial products (`signed_pp`, `exp`) and forms each term as `signed_pp << exp`.
- Accumulates the terms of one group into a saturating signed sum.
- Presents the finished sum with a valid/ready handshake to the output/writeback stage.
- Supplies the sequential accumulation that turns per-digit partial products into complete image×weight dot-product results.

---
 rtl/sd4_pkg.sv | 31 +++
 rtl/sd4_term_shifter.sv | 22 ++
 rtl/sd4_accumulator.sv | 120 ++++++++++++
 tb/tb_sd4_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sd4_pkg.sv
// Shared types, defaults and saturation-limit helpers for the SD4 accumulator slice.
package sd4_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } sd4_state_e;

   localparam int ACC_W_DEF = 24;
   localparam int CNT_W_DEF = 8;
   localparam int EXP_MAX   = 15;
   localparam int PP_W      = 5;

   // A legal term is at most PP_W+EXP_MAX bits; narrower accumulators still see it exactly.
   localparam int TERM_FULL_W = PP_W + EXP_MAX;

   function automatic int term_w(input int acc_w);
      return (acc_w > TERM_FULL_W) ? acc_w : TERM_FULL_W;
   endfunction

   function automatic longint sat_hi(input int acc_w);
      return (longint'(1) << (acc_w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int acc_w);
      return -(longint'(1) << (acc_w - 1));
   endfunction

endpackage

// File: rtl/sd4_term_shifter.sv
// Combinational term former: sign-extends the partial product and shifts it by exp.
module sd4_term_shifter
   import sd4_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int TERM_W = term_w(ACC_W)
) (
   input  logic [4:0]        signed_pp,
   input  logic [4:0]        exp,
   output logic [TERM_W-1:0] term,
   output logic              exp_err
);

   logic [TERM_W-1:0] pp_ext;

   always_comb begin
      pp_ext  = {{(TERM_W-5){signed_pp[4]}}, signed_pp};
      exp_err = (exp > 5'(EXP_MAX));
      term    = exp_err ? '0 : (pp_ext << exp[3:0]);
   end

endmodule

// File: rtl/sd4_accumulator.sv
// Two-stage saturating accumulator for SD4 partial products with a valid/ready result port.
module sd4_accumulator
   import sd4_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       signed_pp,
   input  logic [4:0]       exp,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] out_cnt,
   output logic             ovf,
   output logic             err,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens only on a rising edge where valid and ready are both high;
   // the sender holds its payload stable until then, and ready never depends on valid.

   localparam int TERM_W = term_w(ACC_W);
   localparam int SUM_W  = TERM_W + 1;
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_hi(ACC_W));
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_lo(ACC_W));
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   sd4_state_e state_q, state_d;
   logic              in_ready_q;
   logic              s1_valid;
   logic [TERM_W-1:0] s1_term;
   logic              s1_err;
   logic [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q, err_q;

   logic [TERM_W-1:0]       term_c;
   logic                    exp_err_c;
   logic                    accept, cnt_full, clamp_hi, clamp_lo;
   logic signed [SUM_W-1:0] sum_c;
   logic [ACC_W-1:0]        acc_next;

   sd4_term_shifter #(.ACC_W(ACC_W), .TERM_W(TERM_W)) u_shifter (
      .signed_pp (signed_pp),
      .exp       (exp),
      .term      (term_c),
      .exp_err   (exp_err_c)
   );

   assign accept   = in_valid && in_ready_q;
   assign cnt_full = (cnt_q == CNT_MAX);

   always_comb begin
      sum_c    = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
               + {{(SUM_W-TERM_W){s1_term[TERM_W-1]}}, s1_term};
      clamp_hi = (sum_c > SAT_HI);
      clamp_lo = (sum_c < SAT_LO);
      acc_next = clamp_hi ? SAT_HI[ACC_W-1:0] :
                 clamp_lo ? SAT_LO[ACC_W-1:0] : sum_c[ACC_W-1:0];
   end

   // DRAIN waits for S1 to empty, so the result is visible two edges after the last accept.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCUM: if (accept) state_d = in_last ? DRAIN : ACCUM;
         DRAIN:       if (!s1_valid) state_d = HOLD;
         HOLD:        if (out_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         s1_valid   <= 1'b0;
         s1_term    <= '0;
         s1_err     <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == IDLE) || (state_d == ACCUM);
         s1_valid   <= accept;
         if (accept) begin
            s1_term <= term_c;
            s1_err  <= exp_err_c | cnt_full;
            if (!cnt_full) cnt_q <= cnt_q + 1'b1;
         end
         if (s1_valid) begin
            acc_q <= acc_next;
            ovf_q <= ovf_q | clamp_hi | clamp_lo;
            err_q <= err_q | s1_err;
         end
         if (state_q == HOLD && out_ready) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == HOLD);
   assign acc_out   = acc_q;
   assign out_cnt   = cnt_q;
   assign ovf       = ovf_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sd4_accumulator.sv
// Directed and randomized checks of sd4_accumulator (ACC_W=8, CNT_W=4) against an arithmetic group model.
module tb_sd4_accumulator;

   localparam int ACC_W = 8;
   localparam int CNT_W = 4;
   localparam int A_MAX = 127;
   localparam int A_MIN = -128;
   localparam int C_MAX = 15;

   logic             clk, rst_n;
   logic             in_valid, in_ready, in_last;
   logic [4:0]       signed_pp, exp;
   logic             out_valid, out_ready;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] out_cnt;
   logic             ovf, err;
   logic [1:0]       dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int q_pp[$];
   int q_e[$];

   sd4_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .signed_pp (signed_pp),
      .exp       (exp),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .out_cnt   (out_cnt),
      .ovf       (ovf),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic add(input int pp, input int e);
      q_pp.push_back(pp);
      q_e.push_back(e);
   endtask

   // Reference: exact pp*2^e per term, clamp after every add, sticky flags, capped count.
   task automatic model(output int m_acc, output int m_cnt, output int m_ovf, output int m_err);
      int s, t;
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
      foreach (q_pp[i]) begin
         if (q_e[i] >= 16) begin
            t = 0;
            m_err = 1;
         end else begin
            t = q_pp[i] * (1 << q_e[i]);
         end
         if (m_cnt == C_MAX) m_err = 1;
         else m_cnt++;
         s = m_acc + t;
         if (s > A_MAX) begin s = A_MAX; m_ovf = 1; end
         else if (s < A_MIN) begin s = A_MIN; m_ovf = 1; end
         m_acc = s;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},  int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_acc_out"},   int'($signed(acc_out)), 0);
      chk({tag, "_out_cnt"},   int'(out_cnt), 0);
      chk({tag, "_ovf"},       int'(ovf), 0);
      chk({tag, "_err"},       int'(err), 0);
   endtask

   // Called at a negedge; returns at a negedge with the block back in IDLE.
   task automatic run_group(input string tag, input int gap_max, input int hold_cycles, input bit early);
      int m_acc, m_cnt, m_ovf, m_err, w, held;
      model(m_acc, m_cnt, m_ovf, m_err);
      foreach (q_pp[i]) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         w = 0;
         while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (w == 50) begin
            chk({tag, "_ready_timeout"}, int'(in_ready), 1);
            q_pp.delete();
            q_e.delete();
            return;
         end
         in_valid  = 1'b1;
         signed_pp = 5'(q_pp[i]);
         exp       = 5'(q_e[i]);
         in_last   = (i == q_pp.size() - 1);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      if (early) out_ready = 1'b1;
      chk({tag, "_ready_fall"}, int'(in_ready), 0);
      chk({tag, "_valid_t1"},   int'(out_valid), 0);
      @(negedge clk);
      chk({tag, "_valid_t2"},   int'(out_valid), 0);
      @(negedge clk);
      chk({tag, "_out_valid"},  int'(out_valid), 1);
      chk({tag, "_acc"},        int'($signed(acc_out)), m_acc);
      chk({tag, "_cnt"},        int'(out_cnt), m_cnt);
      chk({tag, "_ovf"},        int'(ovf), m_ovf);
      chk({tag, "_err"},        int'(err), m_err);
      held = int'($signed(acc_out));
      if (!early) begin
         repeat (hold_cycles) begin
            @(negedge clk);
            chk({tag, "_hold_acc"},   int'($signed(acc_out)), held);
            chk({tag, "_hold_ready"}, int'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      // A term offered on the handshake edge must be ignored.
      in_valid  = 1'b1;
      signed_pp = 5'd3;
      exp       = 5'd0;
      chk({tag, "_no_bypass"}, int'(in_ready), 0);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_idle_valid"}, int'(out_valid), 0);
      chk({tag, "_idle_ready"}, int'(in_ready), 1);
      chk({tag, "_idle_cnt"},   int'(out_cnt), 0);
      q_pp.delete();
      q_e.delete();
   endtask

   initial begin
      int len, pp, e;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      signed_pp = '0;
      exp       = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready_rise", int'(in_ready), 1);

      add(7, 0); add(7, 1);
      run_group("two_terms", 0, 0, 0);
      add(-7, 2);
      run_group("single_neg", 0, 0, 0);
      add(15, 4); add(1, 0);
      run_group("sat_pos", 0, 0, 0);
      add(-1, 0);
      run_group("after_sat", 0, 0, 0);
      add(3, 17); add(2, 0);
      run_group("exp_err", 0, 0, 0);
      add(-16, 5); add(-16, 3);
      run_group("sat_neg", 0, 0, 0);
      add(5, 1); add(-3, 0); add(2, 2);
      run_group("hold5", 0, 5, 0);
      add(4, 3);
      run_group("early_ready", 0, 0, 1);
      for (int i = 0; i < 17; i++) add(1, 0);
      run_group("cnt_limit", 0, 0, 0);

      in_valid  = 1'b1;
      signed_pp = 5'd1;
      exp       = 5'd0;
      in_last   = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_reset_ready", int'(in_ready), 1);
      add(4, 0);
      run_group("post_reset", 0, 0, 0);

      for (int g = 0; g < 40; g++) begin
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            pp = int'($urandom_range(0, 31)) - 16;
            e  = $urandom_range(0, 17);
            add(pp, e);
         end
         run_group("rand", 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
